sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Single-clock, parametrised successor to the team's asynchronous FIFO. It is generalised in data width, depth, almost-full/almost-empty thresholds and read mode (standard or first-word-fall-through). It adds an occupancy count and sticky overflow/underflow error flags. It buffers data between two producer/consumer stages in the same clock domain, for example in front of the seven-segment display path, where the gray-code pointer synchronisers of the async FIFO are unnecessary.

## Interface
- DSIZE, 8, data width in bits
- ASIZE, 4, address width; depth = 2**ASIZE
- AFULL_TH, 14, walmost_full asserts when count >= AFULL_TH (range 1..2**ASIZE)
- AEMPTY_TH, 2, ralmost_empty asserts when count <= AEMPTY_TH (range 0..2**ASIZE-1)
- FWFT, 0, 0 = standard read (rdata one cycle after accepted rinc); 1 = first-word-fall-through

- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- winc  in  1  write request
- wdata  in  DSIZE  write data
- wfull  out  1  FIFO full; writes ignored while high
- walmost_full  out  1  count >= AFULL_TH
- rinc  in  1  read request
- rdata  out  DSIZE  read data
- rempty  out  1  FIFO empty; reads ignored while high
- ralmost_empty  out  1  count <= AEMPTY_TH
- count  out  ASIZE+1  current occupancy, 0..2**ASIZE
- clr_err  in  1  clears overflow/underflow
- overflow  out  1  sticky: winc seen while wfull
- underflow  out  1  sticky: rinc seen while rempty

## Operation
- Pointers wptr/rptr are ASIZE+1 bits wide; the MSB is the wrap bit. Address = low ASIZE bits. Pointers wrap naturally modulo 2**(ASIZE+1).
- Full: wptr[ASIZE] != rptr[ASIZE] and the low bits are equal. Empty: wptr == rptr. count = wptr - rptr (ASIZE+1-bit subtraction).
- Write accepted iff winc && !wfull: mem[wptr addr] <= wdata; wptr++.
- Read accepted iff rinc && !rempty: rptr++.
  - FWFT=0: rdata <= mem[rptr addr] on the same edge.
  - FWFT=1: rdata = mem[rptr addr] combinationally whenever !rempty; the consumer takes rdata in the cycle it asserts rinc.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
- When full, the write is rejected even if a read is accepted in the same cycle, because flags reflect registered state. When empty, the read is rejected even if a write is accepted in the same cycle.
- Rejected write: memory and wptr unchanged; overflow <= 1. Rejected read: rptr and rdata unchanged; underflow <= 1.
- overflow and underflow hold until clr_err or reset. If clr_err and a new error occur in the same cycle, the flag ends at 1 (set wins).
- Reset (rst_n=0 at posedge): wptr=rptr=0, count=0, rempty=1, wfull=0, walmost_full=(AFULL_TH==0 ? 1 : 0), ralmost_empty=1, overflow=underflow=0, registered rdata=0.
  - Memory contents are not cleared.
  - A reset in the middle of a transfer discards all stored data. winc/rinc presented in the reset cycle are ignored and do not set error flags.

## Timing
- wfull, rempty, walmost_full, ralmost_empty and count are registered and reflect pointers after the last edge. Settled value = combinational decode of the registered pointers.
- Write at edge N: count, rempty, walmost_full are updated after edge N.
- Read latency:
  - FWFT=0: rdata valid after the edge that accepts rinc (1 cycle).
  - FWFT=1: head word is visible 0 cycles after rempty falls, i.e. the word written at edge N appears on rdata after edge N.
- Maximum throughput is one write and one read per cycle, sustained, at any occupancy strictly between empty and full.

## Structure
- Shared package fifo_pkg holds:
  - a ptr_t width helper (ASIZE+1)
  - an occupancy-compare function shared by both almost thresholds
  - the FWFT mode constants (MODE_STD=0, MODE_FWFT=1)
- Sub-module fifo_mem: 2**ASIZE x DSIZE array, synchronous write, asynchronous read. The top adds the output register when FWFT=0.
- Pointer/flag/error logic stays in the top. Target size is about 200 lines total.

## Test plan
1. Fill (DSIZE=8, ASIZE=4, FWFT=0): after reset, write 0x01..0x10 on 16 consecutive cycles.
   - Expect walmost_full=1 after the 14th write, wfull=1 and count=16 after the 16th.
   - A 17th write with 0xAA is dropped, overflow=1, contents unchanged.
2. Drain (same config, continuing from test 1): read 16 times.
   - rdata = 0x01..0x10 in order, each one cycle after its rinc.
   - ralmost_empty=1 once count<=2, rempty=1 after the 16th read.
   - A 17th read sets underflow=1 and rdata stays 0x10.
3. Simultaneous and wrap: with count=8, assert winc and rinc for 40 cycles with incrementing data.
   - count stays 8 throughout, pointers wrap twice, and output order matches input order exactly.
4. FWFT=1: write 0x5A into an empty FIFO.
   - rempty=0 and rdata=0x5A after that edge with no rinc.
   - rinc then gives rempty=1 on the next edge.
5. Boundary and reset:
   - Full FIFO with winc+rinc: read accepted, write rejected, count=15, overflow=1.
   - clr_err for one cycle: overflow=0.
   - Assert rst_n=0 with count=9: after the edge, count=0, rempty=1, all flags at their reset values.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: pointer width helper,
// occupancy threshold compare and read-mode constants.
package fifo_pkg;

    localparam int unsigned MODE_STD  = 0;
    localparam int unsigned MODE_FWFT = 1;

    // Pointer width carries one extra wrap bit above the address.
    function automatic int unsigned ptr_width(input int unsigned asize);
        return asize + 1;
    endfunction

    // Threshold test shared by almost-full (at_least=1) and almost-empty (at_least=0).
    function automatic logic occ_hit(input int unsigned occ,
                                     input int unsigned th,
                                     input logic        at_least);
        return at_least ? (occ >= th) : (occ <= th);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake bundle between a producer/consumer (master) and the FIFO (slave).
// Write side: winc, wdata, wfull, walmost_full. Read side: rinc, rdata,
// rempty, ralmost_empty. Status: count, overflow, underflow, clr_err.
interface sync_fifo_param_if #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 4
) ();
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             walmost_full;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             clr_err;
    logic             overflow;
    logic             underflow;

    modport master (
        output winc, wdata, rinc, clr_err,
        input  wfull, walmost_full, rdata, rempty, ralmost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc, clr_err,
        output wfull, walmost_full, rdata, rempty, ralmost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: synchronous write, asynchronous read.
// Ports: clk, we, waddr, wdata, raddr, rdata.
module fifo_mem #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);
    localparam int unsigned DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost thresholds,
// sticky overflow/underflow and standard or first-word-fall-through read.
// Ports: clk, rst_n (synchronous, active-low), bus (slave side of
// sync_fifo_param_if carrying all handshake, data and status signals).
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned ASIZE     = 4,
    parameter int unsigned AFULL_TH  = 14,
    parameter int unsigned AEMPTY_TH = 2,
    parameter int unsigned FWFT      = MODE_STD
) (
    input logic               clk,
    input logic               rst_n,
    sync_fifo_param_if.slave  bus
);
    localparam int unsigned PW = ptr_width(ASIZE);

    logic [PW-1:0]    wptr, rptr, wptr_nxt, rptr_nxt, cnt_nxt, count_q;
    logic             full_q, empty_q, afull_q, aempty_q, ovf_q, udf_q;
    logic             wr_ok, rd_ok;
    logic [DSIZE-1:0] mem_rdata;

    // Accept decisions use registered flags, so a same-cycle read never frees a full slot.
    assign wr_ok = bus.winc && !full_q && rst_n;
    assign rd_ok = bus.rinc && !empty_q && rst_n;

    // Next pointers and the occupancy they imply.
    always_comb begin
        wptr_nxt = wptr + PW'(wr_ok);
        rptr_nxt = rptr + PW'(rd_ok);
        cnt_nxt  = wptr_nxt - rptr_nxt;
    end

    // Pointer, flag and error registers; flags decode the next pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= occ_hit(0, AFULL_TH, 1'b1);
            aempty_q <= occ_hit(0, AEMPTY_TH, 1'b0);
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr     <= wptr_nxt;
            rptr     <= rptr_nxt;
            count_q  <= cnt_nxt;
            full_q   <= (wptr_nxt[ASIZE] != rptr_nxt[ASIZE]) &&
                        (wptr_nxt[ASIZE-1:0] == rptr_nxt[ASIZE-1:0]);
            empty_q  <= (wptr_nxt == rptr_nxt);
            afull_q  <= occ_hit(32'(cnt_nxt), AFULL_TH, 1'b1);
            aempty_q <= occ_hit(32'(cnt_nxt), AEMPTY_TH, 1'b0);
            // A new error in the clearing cycle keeps the flag set.
            ovf_q    <= (bus.winc && full_q)  || (ovf_q && !bus.clr_err);
            udf_q    <= (bus.rinc && empty_q) || (udf_q && !bus.clr_err);
        end
    end

    fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (bus.wdata),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (mem_rdata)
    );

    // Read data path: head word shown directly in FWFT mode, registered otherwise.
    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            assign bus.rdata = mem_rdata;
        end else begin : g_std
            logic [DSIZE-1:0] rdata_q;
            always_ff @(posedge clk) begin
                if (!rst_n)     rdata_q <= '0;
                else if (rd_ok) rdata_q <= mem_rdata;
            end
            assign bus.rdata = rdata_q;
        end
    endgenerate

    assign bus.wfull         = full_q;
    assign bus.rempty        = empty_q;
    assign bus.walmost_full  = afull_q;
    assign bus.ralmost_empty = aempty_q;
    assign bus.count         = count_q;
    assign bus.overflow      = ovf_q;
    assign bus.underflow     = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one standard-read and one FWFT instance driven
// with identical stimulus and compared every cycle against a queue model.
module tb_sync_fifo_param;
    localparam int unsigned DSIZE     = 8;
    localparam int unsigned ASIZE     = 4;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned AFULL_TH  = 14;
    localparam int unsigned AEMPTY_TH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) if_std ();
    sync_fifo_param_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) if_fw ();

    sync_fifo_param #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_TH(AFULL_TH),
        .AEMPTY_TH(AEMPTY_TH), .FWFT(0)
    ) u_std (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_std.slave)
    );

    sync_fifo_param #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_TH(AFULL_TH),
        .AEMPTY_TH(AEMPTY_TH), .FWFT(1)
    ) u_fw (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_fw.slave)
    );

    // Reference model: contents as a queue, sticky errors, last word read.
    logic [7:0] q[$];
    logic       m_ovf, m_udf;
    logic [7:0] m_rdata;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        int unsigned c;
        c = q.size();
        check("std.count",         32'(if_std.count),         c);
        check("std.wfull",         32'(if_std.wfull),         32'(c == DEPTH));
        check("std.rempty",        32'(if_std.rempty),        32'(c == 0));
        check("std.walmost_full",  32'(if_std.walmost_full),  32'(c >= AFULL_TH));
        check("std.ralmost_empty", 32'(if_std.ralmost_empty), 32'(c <= AEMPTY_TH));
        check("std.overflow",      32'(if_std.overflow),      32'(m_ovf));
        check("std.underflow",     32'(if_std.underflow),     32'(m_udf));
        check("std.rdata",         32'(if_std.rdata),         32'(m_rdata));
        check("fw.count",          32'(if_fw.count),          c);
        check("fw.rempty",         32'(if_fw.rempty),         32'(c == 0));
        check("fw.overflow",       32'(if_fw.overflow),       32'(m_ovf));
        if (c != 0) check("fw.rdata", 32'(if_fw.rdata), 32'(q[0]));
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
        if_std.winc = w; if_std.wdata = d; if_std.rinc = r; if_std.clr_err = c;
        if_fw.winc  = w; if_fw.wdata  = d; if_fw.rinc  = r; if_fw.clr_err  = c;
    endtask

    // One clock with the given inputs, then model update and full output check.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        bit full, empty;
        drive(w, d, r, c);
        @(posedge clk);
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        m_ovf = (w && full)  ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_udf = (r && empty) ? 1'b1 : (c ? 1'b0 : m_udf);
        if (r && !empty) m_rdata = q.pop_front();
        if (w && !full)  q.push_back(d);
        #1;
        check_all();
    endtask

    // Reset with both requests asserted: they must be ignored.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 8'hEE, 1'b1, 1'b0);
        @(posedge clk);
        q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_rdata = 8'h00;
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] v;
        m_ovf = 1'b0; m_udf = 1'b0; m_rdata = 8'h00;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Fill 0x01..0x10, then a dropped 0xAA.
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check("fill.overflow", 32'(if_std.overflow), 32'd1);

        // Drain in order, then one extra read.
        for (int i = 1; i <= 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain.rdata_hold", 32'(if_std.rdata), 32'h10);
        check("drain.underflow",  32'(if_std.underflow), 32'd1);

        // Simultaneous traffic at count 8 across two pointer wraps.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        v = 8'h20;
        for (int i = 0; i < 8; i++) begin step(1'b1, v, 1'b0, 1'b0); v++; end
        for (int i = 0; i < 40; i++) begin step(1'b1, v, 1'b1, 1'b0); v++; end
        check("wrap.count", 32'(if_std.count), 32'd8);

        // FWFT head visibility from empty.
        do_reset();
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        check("fwft.head", 32'(if_fw.rdata), 32'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft.empty", 32'(if_fw.rempty), 32'd1);

        // Full with read+write, clear errors, reset mid-occupancy.
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check("full_rw.count", 32'(if_std.count), 32'd15);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr.overflow", 32'(if_std.overflow), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_reset.count", 32'(if_std.count), 32'd9);
        do_reset();

        // Randomized phases biased toward filling and draining.
        for (int p = 0; p < 8; p++) begin
            int unsigned wp;
            wp = (p % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 250; i++)
                step($urandom_range(0, 99) < wp, 8'($urandom),
                     $urandom_range(0, 99) < (100 - wp),
                     $urandom_range(0, 99) < 3);
        end
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
